calc_req_scheduler: RTL and testbench
=====================================

# calc_req_scheduler

Front-end scheduler for the calculator: captures two-cycle command/operand requests from four requester ports, arbitrates them onto one shared ALU through a request/acknowledge handshake, and routes each ALU result back to the originating port's response outputs. It sits between the four `reqN_*` input ports and the single arithmetic/shift unit. It also enforces one outstanding request per port, answers invalid commands locally, and recovers from a hung ALU with a watchdog.

## Interface
- `TIMEOUT`, default 64: cycles `alu_req` may stay high without `alu_ack` before the request is aborted.
- `c_clk` in 1: clock, all logic on rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `reqN_cmd_in` in 4 (N=1..4): command. 0 no-op, 1 add, 2 sub, 5 shl, 6 shr, others invalid.
- `reqN_data_in` in 32 (N=1..4): operand1 with the command cycle, operand2 on the following cycle.
- `out_respN` out 2 (N=1..4): 0 none, 1 success, 2 invalid/overflow/underflow, 3 internal error.
- `out_dataN` out 32 (N=1..4): result, valid only while `out_respN` != 0.
- `alu_req` out 1: request to ALU, held until acknowledged.
- `alu_cmd` out 4, `alu_op1` out 32, `alu_op2` out 32: stable while `alu_req` is high.
- `alu_ack` in 1: ALU completion, single-cycle pulse.
- `alu_resp` in 2, `alu_dout` in 32: ALU response/result, valid when `alu_ack` is high.

## Operation
- Per-port FSM: IDLE -> OP2 -> PEND -> ACTIVE -> IDLE.
  - IDLE: a nonzero cmd is sampled and stored with operand1, then goes to OP2. Cmd 0 is ignored.
  - OP2: operand2 is sampled unconditionally, then goes to PEND. The cmd input is ignored in this cycle.
  - PEND: waits for a grant.
  - ACTIVE: waits until its response has been driven.
- Commands arriving while a port is in OP2, PEND or ACTIVE are dropped without any response.
  - Exception: the port's own response cycle counts as IDLE for capture, so a new command presented then is accepted.
- Scheduler FSM: SIDLE, ISSUE, RESP.
  - SIDLE: if any port is in PEND, grant one per arbitration, move that port to ACTIVE.
    - Valid cmd: go to ISSUE.
    - Invalid cmd: go to RESP with resp 2, data 0, and no ALU transaction.
  - ISSUE: `alu_req`=1. On `alu_ack`, latch `alu_resp`/`alu_dout` and go to RESP. If the watchdog reaches `TIMEOUT`, drop `alu_req` and go to RESP with resp 3, data 0.
  - RESP: drive the latched response on the granted port for exactly one cycle. All other ports output 0. Then return to SIDLE.
- Arbitration: round-robin.
  - A last-grant pointer (reset value port 4) is updated on each grant.
  - Search starts at pointer+1, wrapping 4->1.
- `alu_ack` outside ISSUE, or arriving after a timeout, is ignored.
- The scheduler performs no arithmetic. ALU response codes pass through unchanged.

## Timing
- Reset: every FSM goes to IDLE/SIDLE. All outputs 0, pointer = 4, watchdog = 0.
- Reset asserted mid-transaction clears immediately and asynchronously. `alu_req` falls without waiting for ack.
- Command sampled at edge N, operand2 at edge N+1.
- Earliest `alu_req` is the cycle after edge N+2, with the ALU idle and no competitors.
- `alu_ack` may arrive in the first `alu_req` cycle. `alu_req` falls the cycle after ack is sampled.
- `out_respN` is asserted in the cycle after ack is sampled and lasts one cycle.
- Minimum command-to-response: 4 cycles with a same-cycle ack. Invalid command: 3 cycles.
- The next grant can occur in the cycle after RESP. Throughput is one request per (ALU latency + 2) cycles.
- Simultaneous PEND on several ports: only one grant per SIDLE cycle. The others stay PEND, with no loss.
- Watchdog counts ISSUE cycles. Abort happens at count == `TIMEOUT`: `alu_req` is high for exactly `TIMEOUT` cycles.

## Configuration
- `CALC_SCHED_FIXED_PRIO_EN`
  - Defined: fixed priority, port 1 > 2 > 3 > 4. The pointer logic is removed.
  - Undefined: round-robin as described above.
  - All other behaviour is identical.

## Test plan
- Reset, then port1 cmd 1, op1 0x00000005, op2 0x00000003, ALU acks resp 1 data 8 in the same cycle -> `alu_cmd`=1, op1=5, op2=3; `out_resp1`=1, `out_data1`=0x8, for one cycle, 4 cycles after the command.
- All four ports issue cmd 2 in the same cycle, ALU ack after 2 cycles -> responses in order port1,2,3,4 under round-robin (port1 first after reset). With `CALC_SCHED_FIXED_PRIO_EN` and port1 re-issuing continuously, port1 starves ports 2–4.
- Port2 cmd 0xF -> no `alu_req`; `out_resp2`=2, `out_data2`=0, 3 cycles after the command.
- Port3 cmd 5, ALU never acks, `TIMEOUT`=64 -> `alu_req` high for 64 cycles; `out_resp3`=3; a late `alu_ack` is ignored; port3 accepts its next command.
- Port4 issues cmd 6 and re-issues cmd 1 while PEND -> the second command is dropped, with exactly one response. A command presented on the response cycle is accepted.
- `reset` asserted while `alu_req`=1 -> all outputs 0 immediately. After release, the first grant goes to port1.

Source files
------------

// File: rtl/calc_req_scheduler_if.sv
// Bundle of the four requester ports, their response outputs, the shared ALU
// handshake and the FSM debug taps of calc_req_scheduler.
interface calc_req_scheduler_if;
  logic [3:0]  req1_cmd_in, req2_cmd_in, req3_cmd_in, req4_cmd_in;
  logic [31:0] req1_data_in, req2_data_in, req3_data_in, req4_data_in;
  logic [1:0]  out_resp1, out_resp2, out_resp3, out_resp4;
  logic [31:0] out_data1, out_data2, out_data3, out_data4;
  logic        alu_req;
  logic [3:0]  alu_cmd;
  logic [31:0] alu_op1, alu_op2;
  logic        alu_ack;
  logic [1:0]  alu_resp;
  logic [31:0] alu_dout;
  logic [1:0]  dbg_sched_state;
  logic [7:0]  dbg_port_state;

  modport slave (
    input  req1_cmd_in, req2_cmd_in, req3_cmd_in, req4_cmd_in,
    input  req1_data_in, req2_data_in, req3_data_in, req4_data_in,
    output out_resp1, out_resp2, out_resp3, out_resp4,
    output out_data1, out_data2, out_data3, out_data4,
    output alu_req, alu_cmd, alu_op1, alu_op2,
    input  alu_ack, alu_resp, alu_dout,
    output dbg_sched_state, dbg_port_state
  );

  modport master (
    output req1_cmd_in, req2_cmd_in, req3_cmd_in, req4_cmd_in,
    output req1_data_in, req2_data_in, req3_data_in, req4_data_in,
    input  out_resp1, out_resp2, out_resp3, out_resp4,
    input  out_data1, out_data2, out_data3, out_data4,
    input  alu_req, alu_cmd, alu_op1, alu_op2,
    output alu_ack, alu_resp, alu_dout,
    input  dbg_sched_state, dbg_port_state
  );
endinterface

// File: rtl/calc_req_scheduler.sv
// Four-port request scheduler for the shared calculator ALU with watchdog.
// Define CALC_SCHED_FIXED_PRIO_EN for fixed priority (port1 highest) instead of round-robin.
module calc_req_scheduler #(
  parameter int TIMEOUT = 64
) (
  input logic                  c_clk,
  input logic                  reset,
  calc_req_scheduler_if.slave  bus
);
  localparam int WD_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {P_IDLE, P_OP2, P_PEND, P_ACTIVE} port_state_e;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP} sched_state_e;

  logic [3:0]   cmd_in [4];
  logic [31:0]  data_in [4];
  port_state_e  pst_q [4];
  logic [3:0]   cmd_q [4];
  logic [31:0]  op1_q [4];
  logic [31:0]  op2_q [4];
  logic [1:0]   out_resp_q [4];
  logic [31:0]  out_data_q [4];
  sched_state_e sst_q;
  logic [1:0]   gnt_q;
  logic [WD_W-1:0] wd_q;
  logic         alu_req_q;
  logic [3:0]   alu_cmd_q;
  logic [31:0]  alu_op1_q, alu_op2_q;
  logic         gnt_vld;
  logic [1:0]   gnt_idx;

  assign cmd_in[0] = bus.req1_cmd_in;   assign data_in[0] = bus.req1_data_in;
  assign cmd_in[1] = bus.req2_cmd_in;   assign data_in[1] = bus.req2_data_in;
  assign cmd_in[2] = bus.req3_cmd_in;   assign data_in[2] = bus.req3_data_in;
  assign cmd_in[3] = bus.req4_cmd_in;   assign data_in[3] = bus.req4_data_in;

  function automatic logic cmd_is_valid(input logic [3:0] c);
    return (c == 4'd1) || (c == 4'd2) || (c == 4'd5) || (c == 4'd6);
  endfunction

`ifdef CALC_SCHED_FIXED_PRIO_EN
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (pst_q[i] == P_PEND) begin
        gnt_vld = 1'b1;
        gnt_idx = 2'(i);
      end
    end
  end
`else
  logic [1:0] last_q;
  logic [1:0] cand;

  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) last_q <= 2'd3;
    else if (sst_q == S_IDLE && gnt_vld) last_q <= gnt_idx;
  end

  // Scan from lowest to highest priority so the last hit (last_q+1) wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = 2'd0;
    cand    = 2'd0;
    for (int k = 4; k >= 1; k--) begin
      cand = last_q + 2'(k);
      if (pst_q[cand] == P_PEND) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end
`endif

  // ALU handshake: alu_req rises with alu_cmd/op1/op2 and holds them stable until
  // alu_ack is sampled high or the watchdog expires; alu_ack counts only in ISSUE.
  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) begin
        pst_q[i]      <= P_IDLE;
        cmd_q[i]      <= 4'd0;
        op1_q[i]      <= 32'd0;
        op2_q[i]      <= 32'd0;
        out_resp_q[i] <= 2'd0;
        out_data_q[i] <= 32'd0;
      end
      sst_q     <= S_IDLE;
      gnt_q     <= 2'd0;
      wd_q      <= '0;
      alu_req_q <= 1'b0;
      alu_cmd_q <= 4'd0;
      alu_op1_q <= 32'd0;
      alu_op2_q <= 32'd0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        out_resp_q[i] <= 2'd0;
        out_data_q[i] <= 32'd0;
        case (pst_q[i])
          P_IDLE: if (cmd_in[i] != 4'd0) begin
            cmd_q[i] <= cmd_in[i];
            op1_q[i] <= data_in[i];
            pst_q[i] <= P_OP2;
          end
          P_OP2: begin
            op2_q[i] <= data_in[i];
            pst_q[i] <= P_PEND;
          end
          P_PEND: if (sst_q == S_IDLE && gnt_vld && gnt_idx == 2'(i)) pst_q[i] <= P_ACTIVE;
          P_ACTIVE: if (sst_q == S_RESP && gnt_q == 2'(i)) begin
            // The response cycle doubles as an idle cycle for capture.
            if (cmd_in[i] != 4'd0) begin
              cmd_q[i] <= cmd_in[i];
              op1_q[i] <= data_in[i];
              pst_q[i] <= P_OP2;
            end else begin
              pst_q[i] <= P_IDLE;
            end
          end
          default: pst_q[i] <= P_IDLE;
        endcase
      end

      case (sst_q)
        S_IDLE: if (gnt_vld) begin
          gnt_q <= gnt_idx;
          if (cmd_is_valid(cmd_q[gnt_idx])) begin
            sst_q     <= S_ISSUE;
            wd_q      <= '0;
            alu_req_q <= 1'b1;
            alu_cmd_q <= cmd_q[gnt_idx];
            alu_op1_q <= op1_q[gnt_idx];
            alu_op2_q <= op2_q[gnt_idx];
          end else begin
            sst_q               <= S_RESP;
            out_resp_q[gnt_idx] <= 2'd2;
          end
        end
        S_ISSUE: begin
          if (bus.alu_ack || wd_q == WD_W'(TIMEOUT - 1)) begin
            sst_q     <= S_RESP;
            wd_q      <= '0;
            alu_req_q <= 1'b0;
            alu_cmd_q <= 4'd0;
            alu_op1_q <= 32'd0;
            alu_op2_q <= 32'd0;
            if (bus.alu_ack) begin
              out_resp_q[gnt_q] <= bus.alu_resp;
              out_data_q[gnt_q] <= bus.alu_dout;
            end else begin
              out_resp_q[gnt_q] <= 2'd3;
            end
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end
        S_RESP:  sst_q <= S_IDLE;
        default: sst_q <= S_IDLE;
      endcase
    end
  end

  assign bus.out_resp1 = out_resp_q[0];  assign bus.out_data1 = out_data_q[0];
  assign bus.out_resp2 = out_resp_q[1];  assign bus.out_data2 = out_data_q[1];
  assign bus.out_resp3 = out_resp_q[2];  assign bus.out_data3 = out_data_q[2];
  assign bus.out_resp4 = out_resp_q[3];  assign bus.out_data4 = out_data_q[3];
  assign bus.alu_req   = alu_req_q;
  assign bus.alu_cmd   = alu_cmd_q;
  assign bus.alu_op1   = alu_op1_q;
  assign bus.alu_op2   = alu_op2_q;
  assign bus.dbg_sched_state = sst_q;
  assign bus.dbg_port_state  = {pst_q[3], pst_q[2], pst_q[1], pst_q[0]};
endmodule

// File: tb/tb_calc_req_scheduler.sv
// Directed bench for calc_req_scheduler: scoreboard of expected port responses
// checked by a monitor, plus cycle-exact checks on the ALU handshake.
module tb_calc_req_scheduler;
  localparam int TIMEOUT = 64;

  // ---------------- clock / reset ----------------
  logic c_clk = 1'b0;
  logic reset = 1'b0;
  always #5 c_clk = ~c_clk;

  calc_req_scheduler_if bus();
  calc_req_scheduler #(.TIMEOUT(TIMEOUT)) dut (.c_clk(c_clk), .reset(reset), .bus(bus.slave));

  logic [3:0]  cmd_drv [4];
  logic [31:0] data_drv [4];
  logic [1:0]  resp_a [4];
  logic [31:0] data_a [4];

  assign bus.req1_cmd_in = cmd_drv[0];  assign bus.req1_data_in = data_drv[0];
  assign bus.req2_cmd_in = cmd_drv[1];  assign bus.req2_data_in = data_drv[1];
  assign bus.req3_cmd_in = cmd_drv[2];  assign bus.req3_data_in = data_drv[2];
  assign bus.req4_cmd_in = cmd_drv[3];  assign bus.req4_data_in = data_drv[3];
  assign resp_a[0] = bus.out_resp1;  assign data_a[0] = bus.out_data1;
  assign resp_a[1] = bus.out_resp2;  assign data_a[1] = bus.out_data2;
  assign resp_a[2] = bus.out_resp3;  assign data_a[2] = bus.out_data3;
  assign resp_a[3] = bus.out_resp4;  assign data_a[3] = bus.out_data4;

  int n_checks = 0;
  int n_fail   = 0;
  logic [35:0] exp_q[$];  // {port[1:0], resp[1:0], data[31:0]}

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- ALU model ----------------
  int alu_delay    = 1;  // ack on this req cycle; 0 = never ack
  int req_cyc      = 0;
  int last_req_len = 0;
  int late_ack_cnt = 0;
  int late_ack_done = 0;

  function automatic logic [31:0] alu_calc(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    case (c)
      4'd1:    return a + b;
      4'd2:    return a - b;
      4'd5:    return a << b[4:0];
      4'd6:    return a >> b[4:0];
      default: return 32'd0;
    endcase
  endfunction

  initial begin
    bus.alu_ack = 1'b0; bus.alu_resp = 2'd0; bus.alu_dout = 32'd0;
    forever begin
      @(negedge c_clk);
      bus.alu_ack = 1'b0; bus.alu_resp = 2'd0; bus.alu_dout = 32'd0;
      if (bus.alu_req) begin
        req_cyc++;
        if (alu_delay != 0 && req_cyc == alu_delay) begin
          bus.alu_ack  = 1'b1;
          bus.alu_resp = 2'd1;
          bus.alu_dout = alu_calc(bus.alu_cmd, bus.alu_op1, bus.alu_op2);
        end
      end else begin
        if (req_cyc != 0) last_req_len = req_cyc;
        req_cyc = 0;
        if (late_ack_cnt != late_ack_done) begin
          late_ack_done++;
          bus.alu_ack  = 1'b1;
          bus.alu_resp = 2'd1;
          bus.alu_dout = 32'hDEAD_BEEF;
        end
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic [35:0] e;
    forever begin
      @(negedge c_clk);
      for (int p = 0; p < 4; p++) begin
        if (resp_a[p] != 2'd0) begin
          if (exp_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_resp: port%0d got resp %0d data 0x%0h expected no response",
                     p + 1, resp_a[p], data_a[p]);
          end else begin
            e = exp_q.pop_front();
            check("resp_port", 32'(p), 32'(e[35:34]));
            check("resp_code", 32'(resp_a[p]), 32'(e[33:32]));
            check("resp_data", data_a[p], e[31:0]);
          end
        end else begin
          check("idle_data_zero", data_a[p], 32'd0);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    reset = 1'b0;
    for (int p = 0; p < 4; p++) begin cmd_drv[p] = 4'd0; data_drv[p] = 32'd0; end
    repeat (3) @(negedge c_clk);
    reset = 1'b1;
    @(negedge c_clk);
  endtask

  // Call at a negedge; returns two negedges later.
  task automatic issue(input int p, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    cmd_drv[p] = c; data_drv[p] = a;
    @(negedge c_clk);
    cmd_drv[p] = 4'd0; data_drv[p] = b;
    @(negedge c_clk);
    data_drv[p] = 32'd0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin @(negedge c_clk); n++; end
    @(negedge c_clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s: %0d responses outstanding after %0d cycles, expected 0", name, exp_q.size(), budget);
      exp_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    for (int p = 0; p < 4; p++) begin cmd_drv[p] = 4'd0; data_drv[p] = 32'd0; end
    repeat (2) @(negedge c_clk);
    check("rst_alu_req", 32'(bus.alu_req), 32'd0);
    check("rst_alu_cmd", 32'(bus.alu_cmd), 32'd0);
    check("rst_alu_op1", bus.alu_op1, 32'd0);
    check("rst_sched_state", 32'(bus.dbg_sched_state), 32'd0);
    check("rst_port_state", 32'(bus.dbg_port_state), 32'd0);
    for (int p = 0; p < 4; p++) check("rst_out_resp", 32'(resp_a[p]), 32'd0);
    reset = 1'b1;
    @(negedge c_clk);

    // T1: add with same-cycle ack, cycle-exact
    alu_delay = 1;
    exp_q.push_back({2'd0, 2'd1, 32'd8});
    issue(0, 4'd1, 32'h5, 32'h3);
    check("t1_req_k2", 32'(bus.alu_req), 32'd0);
    @(negedge c_clk);
    check("t1_req_k3", 32'(bus.alu_req), 32'd1);
    check("t1_alu_cmd", 32'(bus.alu_cmd), 32'd1);
    check("t1_alu_op1", bus.alu_op1, 32'd5);
    check("t1_alu_op2", bus.alu_op2, 32'd3);
    check("t1_resp_k3", 32'(resp_a[0]), 32'd0);
    @(negedge c_clk);
    check("t1_resp_k4", 32'(resp_a[0]), 32'd1);
    check("t1_data_k4", data_a[0], 32'd8);
    check("t1_req_k4", 32'(bus.alu_req), 32'd0);
    @(negedge c_clk);
    check("t1_resp_k5", 32'(resp_a[0]), 32'd0);
    wait_drain("t1_drain", 10);

    // T2: four simultaneous subs, round-robin from port1 after reset
    do_reset();
    alu_delay = 2;
    exp_q.push_back({2'd0, 2'd1, 32'd7});
    exp_q.push_back({2'd1, 2'd1, 32'd15});
    exp_q.push_back({2'd2, 2'd1, 32'd99});
    exp_q.push_back({2'd3, 2'd1, 32'd0});
    for (int p = 0; p < 4; p++) cmd_drv[p] = 4'd2;
    data_drv[0] = 32'd10; data_drv[1] = 32'd20; data_drv[2] = 32'd100; data_drv[3] = 32'd7;
    @(negedge c_clk);
    for (int p = 0; p < 4; p++) cmd_drv[p] = 4'd0;
    data_drv[0] = 32'd3; data_drv[1] = 32'd5; data_drv[2] = 32'd1; data_drv[3] = 32'd7;
    @(negedge c_clk);
    for (int p = 0; p < 4; p++) data_drv[p] = 32'd0;
    wait_drain("t2_drain", 40);

    // T3: invalid command answered locally
    alu_delay = 1;
    exp_q.push_back({2'd1, 2'd2, 32'd0});
    issue(1, 4'hF, 32'h1234, 32'h5678);
    check("t3_req_k2", 32'(bus.alu_req), 32'd0);
    @(negedge c_clk);
    check("t3_resp_k3", 32'(resp_a[1]), 32'd2);
    check("t3_data_k3", data_a[1], 32'd0);
    check("t3_req_k3", 32'(bus.alu_req), 32'd0);
    wait_drain("t3_drain", 10);

    // T4: watchdog abort, late ack ignored, port recovers
    alu_delay = 0;
    exp_q.push_back({2'd2, 2'd3, 32'd0});
    issue(2, 4'd5, 32'd1, 32'd4);
    wait_drain("t4_drain", 100);
    @(negedge c_clk);
    check("t4_req_len", 32'(last_req_len), 32'(TIMEOUT));
    late_ack_cnt++;
    repeat (4) @(negedge c_clk);
    check("t4_req_after_late_ack", 32'(bus.alu_req), 32'd0);
    alu_delay = 1;
    exp_q.push_back({2'd2, 2'd1, 32'd16});
    issue(2, 4'd5, 32'd1, 32'd4);
    wait_drain("t4_recover", 20);

    // T5: commands while busy are dropped; response cycle accepts a new one
    alu_delay = 3;
    exp_q.push_back({2'd3, 2'd1, 32'h10});
    exp_q.push_back({2'd3, 2'd1, 32'd5});
    cmd_drv[3] = 4'd6; data_drv[3] = 32'h80;
    @(negedge c_clk);
    cmd_drv[3] = 4'd1; data_drv[3] = 32'd3;
    @(negedge c_clk);
    cmd_drv[3] = 4'd1; data_drv[3] = 32'd55;
    @(negedge c_clk);
    cmd_drv[3] = 4'd1; data_drv[3] = 32'd55;
    @(negedge c_clk);
    cmd_drv[3] = 4'd0; data_drv[3] = 32'd0;
    n = 4;
    while (resp_a[3] == 2'd0 && n < 30) begin @(negedge c_clk); n++; end
    check("t5_latency", 32'(n), 32'd6);
    cmd_drv[3] = 4'd2; data_drv[3] = 32'd9;
    @(negedge c_clk);
    cmd_drv[3] = 4'd0; data_drv[3] = 32'd4;
    @(negedge c_clk);
    data_drv[3] = 32'd0;
    wait_drain("t5_drain", 30);

    // T6: asynchronous reset during ISSUE, then pointer restarts at port1
    do_reset();
    alu_delay = 0;
    issue(0, 4'd1, 32'd1, 32'd1);
    n = 0;
    while (!bus.alu_req && n < 10) begin @(negedge c_clk); n++; end
    check("t6_req_seen", 32'(bus.alu_req), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("t6_async_req", 32'(bus.alu_req), 32'd0);
    check("t6_async_cmd", 32'(bus.alu_cmd), 32'd0);
    check("t6_async_sched", 32'(bus.dbg_sched_state), 32'd0);
    check("t6_async_ports", 32'(bus.dbg_port_state), 32'd0);
    @(negedge c_clk);
    reset = 1'b1;
    @(negedge c_clk);
    alu_delay = 1;
    exp_q.push_back({2'd0, 2'd1, 32'd2});
    exp_q.push_back({2'd3, 2'd1, 32'd7});
    cmd_drv[0] = 4'd1; data_drv[0] = 32'd1;
    cmd_drv[3] = 4'd1; data_drv[3] = 32'd3;
    @(negedge c_clk);
    cmd_drv[0] = 4'd0; data_drv[0] = 32'd1;
    cmd_drv[3] = 4'd0; data_drv[3] = 32'd4;
    @(negedge c_clk);
    data_drv[0] = 32'd0; data_drv[3] = 32'd0;
    wait_drain("t6_drain", 20);

    repeat (3) @(negedge c_clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
